// File: rtl/gate_bist_pkg.sv
// Shared types and truth-table constants for the 2-input gate BIST.
// Optional fail logging in gate_bist is enabled with GATE_BIST_ERRLOG_EN.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Truth tables are indexed by {a,b}; bit 3 is the a=1,b=1 response.
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;

   localparam int SETTLE_MAX = 15;

   function automatic logic expected_y(input logic [3:0] tt, input logic [1:0] vec);
      return tt[vec];
   endfunction

endpackage

// File: rtl/gate_bist_settle_timer.sv
// Loadable down-counter that flags the last cycle of a settle window.
// Loading SETTLE_CYCLES yields exactly SETTLE_CYCLES cycles of run before expiry.
module settle_timer
   import gate_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic expired
);

   localparam logic [3:0] LOAD_VALUE = 4'(SETTLE_CYCLES);

   logic [3:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 4'd0;
      end else if (load) begin
         count <= LOAD_VALUE;
      end else if (run && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   // Expiry is flagged in the final held cycle so the FSM leaves on the next edge.
   assign expired = run && (count == 4'd1);

endmodule

// File: rtl/gate_bist.sv
// Built-in self test for a 2-input gate: sweeps {a,b} = 00..11 and counts mismatches.
// Define GATE_BIST_ERRLOG_EN to add fail_vec/fail_valid first-failure logging.
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter logic [3:0] TRUTH_TABLE   = TT_NAND,
   parameter int         SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       gate_y,
   output logic       gate_a,
   output logic       gate_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count
`ifdef GATE_BIST_ERRLOG_EN
   ,
   output logic [1:0] fail_vec,
   output logic       fail_valid
`endif
);

   localparam logic [1:0] IDLE   = ST_IDLE;
   localparam logic [1:0] SETTLE = ST_SETTLE;
   localparam logic [1:0] CHECK  = ST_CHECK;
   localparam logic [1:0] DONE   = ST_DONE;

   logic [1:0] state;
   logic [1:0] vec;
   logic       mismatch;
   logic [2:0] err_next;
   logic       timer_load;
   logic       timer_run;
   logic       settle_expired;

   // X or Z on gate_y must count as a failure, hence the case inequality.
   assign mismatch   = (gate_y !== expected_y(TRUTH_TABLE, vec));
   assign err_next   = err_count + {2'b00, mismatch};
   assign timer_load = ((state == IDLE) && start) || ((state == CHECK) && (vec != 2'd3));
   assign timer_run  = (state == SETTLE);

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (timer_load),
      .run     (timer_run),
      .expired (settle_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         vec       <= 2'd0;
         gate_a    <= 1'b0;
         gate_b    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  vec       <= 2'd0;
                  gate_a    <= 1'b0;
                  gate_b    <= 1'b0;
                  err_count <= 3'd0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_expired) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               err_count <= err_next;
               if (vec == 2'd3) begin
                  gate_a <= 1'b0;
                  gate_b <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  pass   <= (err_next == 3'd0);
                  state  <= DONE;
               end else begin
                  vec              <= vec + 2'd1;
                  {gate_a, gate_b} <= vec + 2'd1;
                  state            <= SETTLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef GATE_BIST_ERRLOG_EN
   // Only the first mismatching vector of a sweep is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_vec   <= 2'd0;
         fail_valid <= 1'b0;
      end else if ((state == IDLE) && start) begin
         fail_vec   <= 2'd0;
         fail_valid <= 1'b0;
      end else if ((state == CHECK) && mismatch && !fail_valid) begin
         fail_vec   <= vec;
         fail_valid <= 1'b1;
      end
   end
`endif

endmodule
